// File: rtl/trdb_pkg.sv
// Shared trace-encoder types: packet format and subformat codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package trdb_pkg;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } subformat_e;

endpackage

// File: rtl/trdb_packet_decoder.sv
// Reassembles length-prefixed byte stream into packets, recovering format/subformat.
// Latency: pkt_valid_o rises 1 cycle after the last payload byte; L+2 cycles per packet.
// Backpressure: byte_ready_o low while a packet waits for pkt_ready_i; pkt_* held stable.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   byte_valid_i/byte_data_i/byte_ready_o input byte stream (header = length, then payload)
//   pkt_valid_o/pkt_ready_i               decoded packet handshake
//   pkt_format_o/pkt_subformat_o          payload[1:0], payload[3:2] (subformat only for F_SYNC)
//   pkt_length_o/pkt_payload_o            byte count and payload (byte k at [8k+:8])
//   err_len_o, err_format_o               1-cycle error pulses
module trdb_packet_decoder
  import trdb_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 16,
  parameter int LEN_W         = $clog2(PAYLOAD_BYTES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_data_i,
  output logic                       byte_ready_o,
  output logic                       pkt_valid_o,
  input  logic                       pkt_ready_i,
  output logic [1:0]                 pkt_format_o,
  output logic [1:0]                 pkt_subformat_o,
  output logic [LEN_W-1:0]           pkt_length_o,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_payload_o,
  output logic                       err_len_o,
  output logic                       err_format_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [7:0] MAX_LEN = 8'(PAYLOAD_BYTES);

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [7:0]                 len_q, len_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic                       err_len_q, err_len_d;
  logic                       err_format_q, err_format_d;

  logic    byte_fire;
  format_e fmt;

  assign byte_ready_o = (state_q != OUTPUT);
  assign byte_fire    = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    payload_d    = payload_q;
    err_len_d    = 1'b0;
    err_format_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_fire) begin
          if (byte_data_i == 8'd0) begin
            err_len_d = 1'b1;
          end else if (byte_data_i > MAX_LEN) begin
            // Oversized packet: swallow its payload so the stream stays framed.
            err_len_d = 1'b1;
            cnt_d     = byte_data_i;
            state_d   = DROP;
          end else begin
            payload_d = '0;
            len_d     = byte_data_i;
            cnt_d     = 8'd0;
            state_d   = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (byte_fire) begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (cnt_q == k[7:0]) payload_d[8*k +: 8] = byte_data_i;
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = OUTPUT;
            // Evaluated on the completed payload so a 1-byte packet is covered.
            err_format_d = (payload_d[1:0] == F_OPT_EXT);
          end
        end
      end
      OUTPUT: begin
        if (pkt_ready_i) state_d = IDLE;
      end
      DROP: begin
        if (byte_fire) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      len_q        <= 8'd0;
      payload_q    <= '0;
      err_len_q    <= 1'b0;
      err_format_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      payload_q    <= payload_d;
      err_len_q    <= err_len_d;
      err_format_q <= err_format_d;
    end
  end

  // Packet fields are gated by the registered state so they read 0 outside OUTPUT.
  assign pkt_valid_o     = (state_q == OUTPUT);
  assign fmt             = format_e'(payload_q[1:0]);
  assign pkt_format_o    = pkt_valid_o ? fmt : F_OPT_EXT;
  assign pkt_subformat_o = (pkt_valid_o && fmt == F_SYNC) ? payload_q[3:2] : SF_START;
  assign pkt_length_o    = pkt_valid_o ? len_q[LEN_W-1:0] : '0;
  assign pkt_payload_o   = pkt_valid_o ? payload_q : '0;
  assign err_len_o       = err_len_q;
  assign err_format_o    = err_format_q;

endmodule
